// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, write, issue and sweep bundle for regfile_sb.
// master drives requests, slave (the register file) returns data/status.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wr0_en;
    logic [AW-1:0]   wr0_addr;
    logic [XLEN-1:0] wr0_data;
    logic            wr1_en;
    logic [AW-1:0]   wr1_addr;
    logic [XLEN-1:0] wr1_data;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic            clr_req;
    logic            clr_busy;
    logic            wr_conflict;

    modport master (
        output rs1_addr, rs2_addr,
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output iss_en, iss_rd, clr_req,
        input  rs1_data, rs2_data,
        input  rs1_busy, rs2_busy,
        input  clr_busy, wr_conflict
    );

    modport slave (
        input  rs1_addr, rs2_addr,
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  iss_en, iss_rd, clr_req,
        output rs1_data, rs2_data,
        output rs1_busy, rs2_busy,
        output clr_busy, wr_conflict
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/2W register file with busy scoreboard,
// optional zero register, optional write bypass and soft-clear sweep.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    localparam int NREGS = 2 ** AW;

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   w_idx_nxt;
    logic            r_clr_busy;
    logic            r_conflict;
    logic [XLEN-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    logic            w_sweep;
    logic            w_wr0_ok;
    logic            w_wr1_ok;
    logic            w_iss_ok;
    logic            w_conflict;
    logic [AW-1:0]   w_ra [2];
    logic [XLEN-1:0] w_rd [2];
    logic            w_rb [2];

    // A sweep owns the array: every request port is masked off.
    assign w_sweep  = (r_state == S_SWEEP);
    assign w_wr0_ok = bus.wr0_en && !w_sweep &&
                      !(ZERO_REG && bus.wr0_addr == '0);
    assign w_wr1_ok = bus.wr1_en && !w_sweep &&
                      !(ZERO_REG && bus.wr1_addr == '0);
    assign w_iss_ok = bus.iss_en && !w_sweep &&
                      !(ZERO_REG && bus.iss_rd == '0);
    assign w_conflict = w_wr0_ok && w_wr1_ok &&
                        (bus.wr0_addr == bus.wr1_addr);

    assign w_ra[0] = bus.rs1_addr;
    assign w_ra[1] = bus.rs2_addr;

    // Read ports: zero reg, then bypass (wr1 over wr0), then array.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd[p] = r_regs[w_ra[p]];
            w_rb[p] = r_busy[w_ra[p]];
            if (ZERO_REG && w_ra[p] == '0) begin
                w_rd[p] = '0;
                w_rb[p] = 1'b0;
            end else if (BYPASS && w_wr1_ok &&
                         bus.wr1_addr == w_ra[p]) begin
                w_rd[p] = bus.wr1_data;
                w_rb[p] = 1'b0;
            end else if (BYPASS && w_wr0_ok &&
                         bus.wr0_addr == w_ra[p]) begin
                w_rd[p] = bus.wr0_data;
                w_rb[p] = 1'b0;
            end
        end
    end

    assign bus.rs1_data    = w_rd[0];
    assign bus.rs2_data    = w_rd[1];
    assign bus.rs1_busy    = w_rb[0];
    assign bus.rs2_busy    = w_rb[1];
    assign bus.clr_busy    = r_clr_busy;
    assign bus.wr_conflict = r_conflict;

    // Scoreboard next state: retire clears, issue set applied last.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_sweep) begin
            w_busy_nxt[r_idx] = 1'b0;
        end else begin
            if (w_wr0_ok) w_busy_nxt[bus.wr0_addr] = 1'b0;
            if (w_wr1_ok) w_busy_nxt[bus.wr1_addr] = 1'b0;
            if (w_iss_ok) w_busy_nxt[bus.iss_rd] = 1'b1;
        end
    end

    // Sweep FSM next state; index walks 0..NREGS-1 and wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (bus.clr_req) begin
                    w_state_nxt = S_SWEEP;
                    w_idx_nxt   = '0;
                end
            end
            S_SWEEP: begin
                w_idx_nxt = r_idx + AW'(1);
                if (r_idx == '1) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Control state: FSM, index, status flags, scoreboard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_clr_busy <= 1'b0;
            r_conflict <= 1'b0;
            r_busy     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_clr_busy <= (w_state_nxt == S_SWEEP);
            r_conflict <= w_conflict;
            r_busy     <= w_busy_nxt;
        end
    end

    // Register array: sweep zeroing, else wr0 then wr1 (wr1 wins).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_sweep) begin
            r_regs[r_idx] <= '0;
        end else begin
            if (w_wr0_ok) r_regs[bus.wr0_addr] <= bus.wr0_data;
            if (w_wr1_ok) r_regs[bus.wr1_addr] <= bus.wr1_data;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed + random checks of regfile_sb,
// bypass and non-bypass instances against a reference model.
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int N    = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bi ();
    regfile_sb_if #(.XLEN(XLEN), .AW(AW)) ni ();

    regfile_sb #(
        .XLEN(XLEN), .AW(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(bi.slave)
    );

    regfile_sb #(
        .XLEN(XLEN), .AW(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) u_nb (
        .clk(clk), .rst(rst), .bus(ni.slave)
    );

    assign ni.rs1_addr = bi.rs1_addr;
    assign ni.rs2_addr = bi.rs2_addr;
    assign ni.wr0_en   = bi.wr0_en;
    assign ni.wr0_addr = bi.wr0_addr;
    assign ni.wr0_data = bi.wr0_data;
    assign ni.wr1_en   = bi.wr1_en;
    assign ni.wr1_addr = bi.wr1_addr;
    assign ni.wr1_data = bi.wr1_data;
    assign ni.iss_en   = bi.iss_en;
    assign ni.iss_rd   = bi.iss_rd;
    assign ni.clr_req  = bi.clr_req;

    logic [31:0] m_regs [N];
    bit          m_busy [N];
    bit          m_sweep;
    int          m_idx;
    bit          m_conf;

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_sweep = 1'b0;
        m_idx   = 0;
        m_conf  = 1'b0;
    endtask

    function automatic bit w0_live();
        return bi.wr0_en && bi.wr0_addr != 0 && !m_sweep;
    endfunction

    function automatic bit w1_live();
        return bi.wr1_en && bi.wr1_addr != 0 && !m_sweep;
    endfunction

    function automatic logic [31:0] exp_rd(
        input logic [4:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && w1_live() && bi.wr1_addr == a)
            return bi.wr1_data;
        if (byp && w0_live() && bi.wr0_addr == a)
            return bi.wr0_data;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] exp_bz(
        input logic [4:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && w1_live() && bi.wr1_addr == a) return '0;
        if (byp && w0_live() && bi.wr0_addr == a) return '0;
        return {31'd0, m_busy[a]};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all();
        chk("b_rs1_data", bi.rs1_data, exp_rd(bi.rs1_addr, 1));
        chk("b_rs2_data", bi.rs2_data, exp_rd(bi.rs2_addr, 1));
        chk("b_rs1_busy", {31'd0, bi.rs1_busy},
            exp_bz(bi.rs1_addr, 1));
        chk("b_rs2_busy", {31'd0, bi.rs2_busy},
            exp_bz(bi.rs2_addr, 1));
        chk("n_rs1_data", ni.rs1_data, exp_rd(bi.rs1_addr, 0));
        chk("n_rs2_data", ni.rs2_data, exp_rd(bi.rs2_addr, 0));
        chk("n_rs1_busy", {31'd0, ni.rs1_busy},
            exp_bz(bi.rs1_addr, 0));
        chk("n_rs2_busy", {31'd0, ni.rs2_busy},
            exp_bz(bi.rs2_addr, 0));
        chk("b_clr_busy", {31'd0, bi.clr_busy}, {31'd0, m_sweep});
        chk("n_clr_busy", {31'd0, ni.clr_busy}, {31'd0, m_sweep});
        chk("b_conflict", {31'd0, bi.wr_conflict}, {31'd0, m_conf});
        chk("n_conflict", {31'd0, ni.wr_conflict}, {31'd0, m_conf});
    endtask

    task automatic m_edge();
        bit w0, w1;
        if (m_sweep) begin
            m_conf = 1'b0;
            m_regs[m_idx] = '0;
            m_busy[m_idx] = 1'b0;
            if (m_idx == N - 1) m_sweep = 1'b0;
            m_idx = (m_idx + 1) % N;
        end else begin
            w0 = w0_live();
            w1 = w1_live();
            m_conf = w0 && w1 && bi.wr0_addr == bi.wr1_addr;
            if (w0) begin
                m_regs[bi.wr0_addr] = bi.wr0_data;
                m_busy[bi.wr0_addr] = 1'b0;
            end
            if (w1) begin
                m_regs[bi.wr1_addr] = bi.wr1_data;
                m_busy[bi.wr1_addr] = 1'b0;
            end
            if (bi.iss_en && bi.iss_rd != 0)
                m_busy[bi.iss_rd] = 1'b1;
            if (bi.clr_req) begin
                m_sweep = 1'b1;
                m_idx   = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk_all();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        bi.wr0_en  = 1'b0;
        bi.wr1_en  = 1'b0;
        bi.iss_en  = 1'b0;
        bi.clr_req = 1'b0;
    endtask

    task automatic wr0(input int a, input logic [31:0] d);
        bi.wr0_en   = 1'b1;
        bi.wr0_addr = 5'(a);
        bi.wr0_data = d;
    endtask

    task automatic wr1(input int a, input logic [31:0] d);
        bi.wr1_en   = 1'b1;
        bi.wr1_addr = 5'(a);
        bi.wr1_data = d;
    endtask

    initial begin
        int cnt;
        rst         = 1'b0;
        bi.rs1_addr = '0;
        bi.rs2_addr = '0;
        bi.wr0_addr = '0;
        bi.wr0_data = '0;
        bi.wr1_addr = '0;
        bi.wr1_data = '0;
        bi.iss_rd   = '0;
        idle();
        m_reset();
        #12 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < N; i++) begin
            bi.rs1_addr = 5'(i);
            bi.rs2_addr = 5'(N - 1 - i);
            #1;
            chk("rst_rs1", bi.rs1_data, 32'h0);
            chk("rst_rs2", bi.rs2_data, 32'h0);
            chk("rst_busy", {31'd0, bi.rs1_busy}, 32'h0);
            tick();
        end

        wr0(5, 32'hDEADBEEF);
        tick();
        idle();
        bi.rs1_addr = 5'd5;
        #1;
        chk("wr_r5", bi.rs1_data, 32'hDEADBEEF);
        tick();

        wr1(7, 32'h12345678);
        bi.rs2_addr = 5'd7;
        #1;
        chk("byp_on", bi.rs2_data, 32'h12345678);
        chk("byp_off", ni.rs2_data, 32'h0);
        tick();
        idle();
        #1;
        chk("byp_off_nxt", ni.rs2_data, 32'h12345678);
        tick();

        wr0(9, 32'h1);
        wr1(9, 32'h2);
        tick();
        idle();
        bi.rs1_addr = 5'd9;
        #1;
        chk("conf_data", bi.rs1_data, 32'h2);
        chk("conf_pulse", {31'd0, bi.wr_conflict}, 32'h1);
        tick();
        chk("conf_once", {31'd0, bi.wr_conflict}, 32'h0);
        wr0(10, 32'h3);
        wr1(11, 32'h4);
        tick();
        idle();
        bi.rs1_addr = 5'd10;
        bi.rs2_addr = 5'd11;
        #1;
        chk("nc_pulse", {31'd0, bi.wr_conflict}, 32'h0);
        chk("nc_r10", bi.rs1_data, 32'h3);
        chk("nc_r11", bi.rs2_data, 32'h4);
        tick();

        bi.iss_en = 1'b1;
        bi.iss_rd = 5'd3;
        tick();
        idle();
        bi.rs1_addr = 5'd3;
        #1;
        chk("iss_busy", {31'd0, bi.rs1_busy}, 32'h1);
        wr0(3, 32'hAA);
        #1;
        chk("ret_busy", {31'd0, bi.rs1_busy}, 32'h0);
        chk("ret_data", bi.rs1_data, 32'hAA);
        chk("ret_nb_busy", {31'd0, ni.rs1_busy}, 32'h1);
        tick();
        idle();

        bi.iss_en = 1'b1;
        bi.iss_rd = 5'd4;
        wr1(4, 32'h44);
        tick();
        idle();
        bi.rs1_addr = 5'd4;
        #1;
        chk("set_wins", {31'd0, bi.rs1_busy}, 32'h1);
        tick();

        wr0(0, 32'hFF);
        bi.iss_en = 1'b1;
        bi.iss_rd = 5'd0;
        tick();
        idle();
        bi.rs1_addr = 5'd0;
        #1;
        chk("r0_data", bi.rs1_data, 32'h0);
        chk("r0_busy", {31'd0, bi.rs1_busy}, 32'h0);
        tick();

        for (int i = 1; i < N; i++) begin
            wr0(i, 32'h0101_0101 * i);
            tick();
        end
        idle();
        bi.clr_req = 1'b1;
        tick();
        bi.clr_req = 1'b0;
        wr0(5, 32'h77);
        cnt = 0;
        while (bi.clr_busy && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("sweep_len", 32'(cnt), 32'd32);
        idle();
        for (int i = 0; i < N; i++) begin
            bi.rs1_addr = 5'(i);
            bi.rs2_addr = 5'(i);
            #1;
            chk("swp_data", bi.rs1_data, 32'h0);
            chk("swp_busy", {31'd0, bi.rs2_busy}, 32'h0);
            tick();
        end

        for (int i = 1; i < N; i++) begin
            wr0(i, 32'hA5A5_0000 + i);
            tick();
        end
        idle();
        bi.clr_req = 1'b1;
        tick();
        bi.clr_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        bi.rs1_addr = 5'd20;
        #1;
        chk("pre_rst", bi.rs1_data, 32'hA5A5_0014);
        rst = 1'b0;
        #1;
        m_reset();
        chk("rst_clr_busy", {31'd0, bi.clr_busy}, 32'h0);
        chk("rst_r20", bi.rs1_data, 32'h0);
        rst = 1'b1;
        tick();
        wr0(2, 32'h55);
        tick();
        idle();
        bi.rs1_addr = 5'd2;
        #1;
        chk("post_rst_r2", bi.rs1_data, 32'h55);
        tick();

        for (int k = 0; k < 600; k++) begin
            bi.wr0_en   = ($urandom_range(0, 1) == 1);
            bi.wr0_addr = 5'($urandom_range(0, 7));
            bi.wr0_data = $urandom;
            bi.wr1_en   = ($urandom_range(0, 1) == 1);
            bi.wr1_addr = 5'($urandom_range(0, 7));
            bi.wr1_data = $urandom;
            bi.iss_en   = ($urandom_range(0, 2) == 0);
            bi.iss_rd   = 5'($urandom_range(0, 7));
            bi.clr_req  = ($urandom_range(0, 149) == 0);
            bi.rs1_addr = 5'($urandom_range(0, 8));
            bi.rs2_addr = 5'($urandom_range(0, N - 1));
            tick();
        end
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the single-write register bank. It provides a two-read, two-write register file with configurable data width and depth, an optional hardwired-zero register, and optional write-to-read bypass. It adds a per-register busy scoreboard for multi-cycle producers and a soft-clear sweep engine. It sits between decode (reads, issue marking) and the writeback stages (two retire ports).

Parameters:
XLEN, 32, data width in bits
AW, 5, register address width; depth NREGS = 2**AW
ZERO_REG, 1, 1 = register 0 reads 0, is never written, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
rs1_addr  input  AW  read port 1 address
rs2_addr  input  AW  read port 2 address
rs1_data  output  XLEN  read port 1 data (combinational)
rs2_data  output  XLEN  read port 2 data (combinational)
rs1_busy  output  1  scoreboard state of rs1_addr (combinational)
rs2_busy  output  1  scoreboard state of rs2_addr (combinational)
wr0_en  input  1  write port 0 enable
wr0_addr  input  AW  write port 0 address
wr0_data  input  XLEN  write port 0 data
wr1_en  input  1  write port 1 enable (priority port)
wr1_addr  input  AW  write port 1 address
wr1_data  input  XLEN  write port 1 data
iss_en  input  1  mark iss_rd busy (instruction issued)
iss_rd  input  AW  destination register being issued
clr_req  input  1  start soft-clear sweep
clr_busy  output  1  sweep in progress (registered)
wr_conflict  output  1  registered one-cycle pulse: both write ports hit same address

Behaviour:
- Reset (rst=0, async): all registers 0, all busy bits 0, FSM=IDLE, sweep index 0, clr_busy=0, wr_conflict=0.
- Writes take effect at the rising edge. An enabled port with address 0 is dropped when ZERO_REG=1.
- wr0 and wr1 enabled to the same non-dropped address: wr1 data stored; wr_conflict=1 in the following cycle only.
- Reads: address 0 with ZERO_REG=1 -> 0. Otherwise, if BYPASS=1 and an enabled, non-dropped write matches, forward its data (wr1 over wr0). Otherwise return the stored value. With BYPASS=0, reads never forward; new data is visible the cycle after the write.
- Scoreboard, one bit per register:
  - iss_en sets bit iss_rd at the edge.
  - Any enabled, non-dropped write clears its bit at the edge.
  - Set and clear on the same register in the same cycle: set wins (newer producer).
  - Bit 0 is never set when ZERO_REG=1.
- rsN_busy = bit[rsN_addr], forced 0 when the read is satisfied by bypass (BYPASS=1, matching write) or the address is zero-reg.
- Sweep FSM:
  - IDLE: clr_req=1 -> SWEEP, index=0.
  - SWEEP: each cycle zeroes reg[index] and clears bit[index], then index++. At index NREGS-1, the zeroing occurs and the FSM returns to IDLE.
  - clr_busy is registered and high for exactly NREGS cycles, starting the cycle after clr_req is sampled.
  - While in SWEEP: writes, iss_en, clr_req ignored; wr_conflict not raised; reads return stored (partially cleared) contents; bypass disabled.
  - Index wraps via AW-bit counter; terminal detection uses the all-ones value.
- Reset asserted mid-sweep: immediate return to reset state; sweep abandoned.

Test Plan:
- Reset then read all 32 addresses -> all rs1_data/rs2_data=0, busy=0; write 0xDEADBEEF to r5 via wr0, next cycle rs1_addr=5 -> 0xDEADBEEF.
- Same-cycle bypass (BYPASS=1): wr1_en, r7, 0x12345678 with rs2_addr=7 in same cycle -> rs2_data=0x12345678 combinationally. Repeat with BYPASS=0 -> old value 0, new value next cycle.
- Dual-write conflict: wr0 r9=0x1, wr1 r9=0x2 -> r9 reads 0x2 afterwards; wr_conflict=1 exactly one cycle; different addresses -> both stored, no pulse.
- Scoreboard:
  - iss_en r3 -> rs1_busy=1 next cycle.
  - wr0 r3=0xAA clears the bit; same-cycle read of r3 shows busy=0 and data 0xAA.
  - iss_en r4 plus wr1 r4 in one cycle -> r4 stays busy.
  - Write to r0 ignored, r0 never busy.
- Sweep: fill r1..r31 with nonzero values, pulse clr_req -> clr_busy high 32 cycles; wr0 during sweep ignored; afterwards all reads 0, all busy 0.
- rst low at sweep cycle 10 -> clr_busy=0 immediately, all registers 0; after release, normal write/read of r2=0x55 works.
